// File: rtl/load_store_unit.sv
// Load/store unit: converts byte/half/word CPU accesses into whole-word data
// memory accesses. Sub-word stores are done as a two-cycle read-modify-write.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accept requests; loads and word stores finish this cycle
// MERGE | write back the merged word captured in the previous cycle
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Mem_Read,
    input  logic        Mem_Write,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] Store_Data,
    output logic [31:0] Load_Data,
    output logic        Stall,
    output logic        Fault,
    output logic        Fault_Valid,
    output logic [31:0] Fault_Addr,
    input  logic        Fault_Clear,
    output logic [31:0] Dmem_Address,
    output logic [31:0] Dmem_Write_Data,
    output logic        Dmem_Read_Enable,
    output logic        Dmem_Write_Enable,
    input  logic [31:0] Dmem_Read_Data
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] merge_addr_q;
    logic [31:0] merge_data_q;
    logic [31:0] merged_word;
    logic [31:0] load_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        access_bad;

    // Size 11 is never legal; halves need bit 0 clear, words need both low bits clear.
    assign access_bad = (Size == 2'b11) ||
                        ((Size == 2'b01) && Address[0]) ||
                        ((Size == 2'b10) && (Address[1:0] != 2'b00));

    assign byte_lane = Dmem_Read_Data[{Address[1:0], 3'b000} +: 8];
    assign half_lane = Dmem_Read_Data[{Address[1], 4'b0000} +: 16];

    // Extend the selected lane of the memory word to a 32-bit load result.
    always_comb begin
        load_ext = Dmem_Read_Data;
        case (Size)
            2'b00:   load_ext = Unsigned ? {24'h0, byte_lane}
                                         : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = Unsigned ? {16'h0, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
            default: load_ext = Dmem_Read_Data;
        endcase
    end

    // Replace the addressed lane of the current memory word with the store data.
    always_comb begin
        merged_word = Dmem_Read_Data;
        case (Size)
            2'b00:   merged_word[{Address[1:0], 3'b000} +: 8]  = Store_Data[7:0];
            2'b01:   merged_word[{Address[1], 4'b0000} +: 16]  = Store_Data[15:0];
            default: merged_word = Dmem_Read_Data;
        endcase
    end

    // Next-state and memory/pipeline outputs; everything is quiet while in reset.
    always_comb begin
        state_d           = state_q;
        Stall             = 1'b0;
        Fault             = 1'b0;
        Dmem_Read_Enable  = 1'b0;
        Dmem_Write_Enable = 1'b0;
        Dmem_Address      = {Address[31:2], 2'b00};
        Dmem_Write_Data   = Store_Data;
        Load_Data         = 32'h0;
        if (!rst_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Mem_Read || Mem_Write) begin
                        if (access_bad) begin
                            Fault = 1'b1;
                        end else if (Mem_Write) begin
                            if (Size == 2'b10) begin
                                Dmem_Write_Enable = 1'b1;
                            end else begin
                                Stall            = 1'b1;
                                Dmem_Read_Enable = 1'b1;
                                state_d          = MERGE;
                            end
                        end else begin
                            Dmem_Read_Enable = 1'b1;
                            Load_Data        = load_ext;
                        end
                    end
                end
                MERGE: begin
                    // The held request is served by this write; inputs are ignored.
                    Dmem_Address      = merge_addr_q;
                    Dmem_Write_Data   = merge_data_q;
                    Dmem_Write_Enable = 1'b1;
                    state_d           = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, merge capture and sticky fault registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            merge_addr_q <= 32'h0;
            merge_data_q <= 32'h0;
            Fault_Valid  <= 1'b0;
            Fault_Addr   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (Stall) begin
                merge_addr_q <= {Address[31:2], 2'b00};
                merge_data_q <= merged_word;
            end
            if (Fault_Clear) begin
                Fault_Valid <= 1'b0;
            end else if (Fault && !Fault_Valid) begin
                Fault_Valid <= 1'b1;
                Fault_Addr  <= Address;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] Store_Data;
    logic [31:0] Load_Data;
    logic        Stall;
    logic        Fault;
    logic        Fault_Valid;
    logic [31:0] Fault_Addr;
    logic        Fault_Clear;
    logic [31:0] Dmem_Address;
    logic [31:0] Dmem_Write_Data;
    logic        Dmem_Read_Enable;
    logic        Dmem_Write_Enable;
    logic [31:0] Dmem_Read_Data;

    logic [31:0] mem [0:1023] = '{default: 32'h0};

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (Dmem_Write_Enable) mem[Dmem_Address[11:2]] <= Dmem_Write_Data;
    end
    assign Dmem_Read_Data = mem[Dmem_Address[11:2]];

    load_store_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .Mem_Read          (Mem_Read),
        .Mem_Write         (Mem_Write),
        .Size              (Size),
        .Unsigned          (Unsigned),
        .Address           (Address),
        .Store_Data        (Store_Data),
        .Load_Data         (Load_Data),
        .Stall             (Stall),
        .Fault             (Fault),
        .Fault_Valid       (Fault_Valid),
        .Fault_Addr        (Fault_Addr),
        .Fault_Clear       (Fault_Clear),
        .Dmem_Address      (Dmem_Address),
        .Dmem_Write_Data   (Dmem_Write_Data),
        .Dmem_Read_Enable  (Dmem_Read_Enable),
        .Dmem_Write_Enable (Dmem_Write_Enable),
        .Dmem_Read_Data    (Dmem_Read_Data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] data);
        Mem_Read   = rd;
        Mem_Write  = wr;
        Size       = sz;
        Unsigned   = uns;
        Address    = addr;
        Store_Data = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        Fault_Clear = 1'b0;
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h21, 32'h1234);
        #2;
        tests++; if ({Stall, Fault, Dmem_Read_Enable, Dmem_Write_Enable} !== 4'b0000) begin
            failed++; $display("FAIL reset_forced_outputs: got %b expected 0000",
                               {Stall, Fault, Dmem_Read_Enable, Dmem_Write_Enable}); end
        tick();
        tick();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #2;
        tests++; if (Fault_Valid !== 1'b0 || Fault_Addr !== 32'h0) begin
            failed++; $display("FAIL reset_fault_regs: got %b/%h expected 0/00000000",
                               Fault_Valid, Fault_Addr); end
        tests++; if (Load_Data !== 32'h0 || Stall !== 1'b0 || Dmem_Read_Enable !== 1'b0) begin
            failed++; $display("FAIL reset_idle_outputs: load %h stall %b re %b expected 0/0/0",
                               Load_Data, Stall, Dmem_Read_Enable); end
        tick();
    endtask

    task automatic test_word_store_load();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        #2;
        tests++; if ({Dmem_Write_Enable, Dmem_Read_Enable, Stall} !== 3'b100 ||
                     Dmem_Address !== 32'h10 || Dmem_Write_Data !== 32'hDEADBEEF) begin
            failed++; $display("FAIL word_store: we/re/stall %b addr %h data %h expected 100 00000010 deadbeef",
                               {Dmem_Write_Enable, Dmem_Read_Enable, Stall}, Dmem_Address, Dmem_Write_Data); end
        tick();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        #2;
        tests++; if (Load_Data !== 32'hDEADBEEF || Stall !== 1'b0 || Dmem_Read_Enable !== 1'b1) begin
            failed++; $display("FAIL word_load: got %h stall %b re %b expected deadbeef 0 1",
                               Load_Data, Stall, Dmem_Read_Enable); end
        tick();
        // preload words used by later scenarios
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        tick();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'hCAFEF00D);
        tick();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_byte_rmw();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA);
        #2;
        tests++; if ({Stall, Dmem_Read_Enable, Dmem_Write_Enable} !== 3'b110) begin
            failed++; $display("FAIL byte_rmw_read: stall/re/we %b expected 110",
                               {Stall, Dmem_Read_Enable, Dmem_Write_Enable}); end
        tick();
        #2;
        tests++; if ({Stall, Dmem_Write_Enable} !== 2'b01 || Dmem_Address !== 32'h20 ||
                     Dmem_Write_Data !== 32'h11AA3344) begin
            failed++; $display("FAIL byte_rmw_write: stall/we %b addr %h data %h expected 01 00000020 11aa3344",
                               {Stall, Dmem_Write_Enable}, Dmem_Address, Dmem_Write_Data); end
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
        #2;
        tests++; if (Load_Data !== 32'hFFFFFFAA || Stall !== 1'b0) begin
            failed++; $display("FAIL byte_load_signed: got %h expected ffffffaa", Load_Data); end
        Unsigned = 1'b1;
        #2;
        tests++; if (Load_Data !== 32'h000000AA) begin
            failed++; $display("FAIL byte_load_unsigned: got %h expected 000000aa", Load_Data); end
        Address = 32'h23;
        #2;
        tests++; if (Load_Data !== 32'h00000011) begin
            failed++; $display("FAIL byte_load_lane3: got %h expected 00000011", Load_Data); end
        Unsigned = 1'b0;
        Address  = 32'h20;
        #2;
        tests++; if (Load_Data !== 32'h00000044) begin
            failed++; $display("FAIL byte_load_lane0: got %h expected 00000044", Load_Data); end
        tick();
    endtask

    task automatic test_half_store();
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h06, 32'hFFFF8001);
        #2;
        tests++; if (Stall !== 1'b1 || Dmem_Write_Enable !== 1'b0) begin
            failed++; $display("FAIL half_store_stall: stall %b we %b expected 1 0", Stall, Dmem_Write_Enable); end
        tick();
        tick();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        #2;
        tests++; if (Load_Data !== 32'h80010000) begin
            failed++; $display("FAIL half_store_word: got %h expected 80010000", Load_Data); end
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h06, 32'h0);
        #2;
        tests++; if (Load_Data !== 32'hFFFF8001) begin
            failed++; $display("FAIL half_load_signed: got %h expected ffff8001", Load_Data); end
        Unsigned = 1'b1;
        #2;
        tests++; if (Load_Data !== 32'h00008001) begin
            failed++; $display("FAIL half_load_unsigned: got %h expected 00008001", Load_Data); end
        Address = 32'h04;
        #2;
        tests++; if (Load_Data !== 32'h00000000) begin
            failed++; $display("FAIL half_load_low: got %h expected 00000000", Load_Data); end
        tick();
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        #2;
        tests++; if ({Fault, Dmem_Read_Enable, Dmem_Write_Enable, Stall} !== 4'b1000 || Load_Data !== 32'h0) begin
            failed++; $display("FAIL misalign_word_load: fault/re/we/stall %b load %h expected 1000 00000000",
                               {Fault, Dmem_Read_Enable, Dmem_Write_Enable, Stall}, Load_Data); end
        tick();
        tests++; if (Fault_Valid !== 1'b1 || Fault_Addr !== 32'h13) begin
            failed++; $display("FAIL misalign_capture: got %b/%h expected 1/00000013", Fault_Valid, Fault_Addr); end
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h41, 32'h5555);
        #2;
        tests++; if ({Fault, Dmem_Read_Enable, Dmem_Write_Enable, Stall} !== 4'b1000) begin
            failed++; $display("FAIL misalign_half_store: fault/re/we/stall %b expected 1000",
                               {Fault, Dmem_Read_Enable, Dmem_Write_Enable, Stall}); end
        tick();
        tests++; if (Fault_Valid !== 1'b1 || Fault_Addr !== 32'h13) begin
            failed++; $display("FAIL misalign_sticky: got %b/%h expected 1/00000013", Fault_Valid, Fault_Addr); end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
        Fault_Clear = 1'b1;
        tick();
        Fault_Clear = 1'b0;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        #2;
        tests++; if (Fault_Valid !== 1'b0) begin
            failed++; $display("FAIL fault_clear_priority: got %b expected 0", Fault_Valid); end
        tick();
    endtask

    task automatic test_reset_mid_rmw();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h51, 32'h77);
        tick();
        rst_n = 1'b0;
        #2;
        tests++; if (Dmem_Write_Enable !== 1'b0) begin
            failed++; $display("FAIL reset_merge_we: got %b expected 0", Dmem_Write_Enable); end
        tick();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #2;
        tests++; if (mem[20] !== 32'hCAFEF00D) begin
            failed++; $display("FAIL reset_merge_mem: got %h expected cafef00d", mem[20]); end
        tests++; if (Dmem_Write_Enable !== 1'b0 || Stall !== 1'b0) begin
            failed++; $display("FAIL reset_merge_idle: we %b stall %b expected 0 0", Dmem_Write_Enable, Stall); end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        #2;
        tests++; if (Load_Data !== 32'hCAFEF00D || Dmem_Read_Enable !== 1'b1) begin
            failed++; $display("FAIL reset_merge_load: got %h re %b expected cafef00d 1", Load_Data, Dmem_Read_Enable); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'hBB);
        tick();
        // in the write-back cycle, an illegal request must be ignored
        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h99, 32'h0);
        #2;
        tests++; if ({Fault, Dmem_Write_Enable, Dmem_Read_Enable} !== 3'b010 ||
                     Dmem_Write_Data !== 32'h11AA33BB || Load_Data !== 32'h0) begin
            failed++; $display("FAIL merge_ignores_req: fault/we/re %b data %h load %h expected 010 11aa33bb 00000000",
                               {Fault, Dmem_Write_Enable, Dmem_Read_Enable}, Dmem_Write_Data, Load_Data); end
        tick();
        tests++; if (Fault_Valid !== 1'b0 || mem[8] !== 32'h11AA33BB) begin
            failed++; $display("FAIL merge_commit: valid %b mem %h expected 0 11aa33bb", Fault_Valid, mem[8]); end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_both_and_illegal();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADF00D);
        #2;
        tests++; if ({Dmem_Write_Enable, Dmem_Read_Enable} !== 2'b10 || Load_Data !== 32'h0) begin
            failed++; $display("FAIL both_requests: we/re %b load %h expected 10 00000000",
                               {Dmem_Write_Enable, Dmem_Read_Enable}, Load_Data); end
        tick();
        tests++; if (mem[12] !== 32'h0BADF00D) begin
            failed++; $display("FAIL both_requests_mem: got %h expected 0badf00d", mem[12]); end
        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h34, 32'h0);
        #2;
        tests++; if ({Fault, Dmem_Read_Enable, Dmem_Write_Enable} !== 3'b100) begin
            failed++; $display("FAIL illegal_size: fault/re/we %b expected 100",
                               {Fault, Dmem_Read_Enable, Dmem_Write_Enable}); end
        tick();
        tests++; if (Fault_Valid !== 1'b1 || Fault_Addr !== 32'h34) begin
            failed++; $display("FAIL illegal_capture: got %b/%h expected 1/00000034", Fault_Valid, Fault_Addr); end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_half_store();
        test_misalign();
        test_reset_mid_rmw();
        test_back_to_back();
        test_both_and_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
